pc_rr_arbiter: RTL and testbench
================================

// Module: pc_rr_arbiter
// PURPOSE
//  Shares one consumer between N_PROD producers in the producer/consumer top.
//  Uses a valid/ready handshake on every port and round-robin grants.
//  Each grant lasts for at most BURST_MAX beats, then arbitration rotates.
//  The block sits between the producer bank and the consumer, inside top.
// PARAMETERS
//  N_PROD     4    number of producers (2..8)
//  DATA_W     4    data width per producer and at the consumer
//  BURST_MAX  4    max beats per grant before forced rotation (1..15)
//  GID_W      2    grant id width, = $clog2(N_PROD)
// PORTS
//  clock       in   1               single clock; all state updates on rising edge
//  reset       in   1               asynchronous, active-low; clears all state immediately
//  prod_valid  in   N_PROD          producer i has data
//  prod_data   in   N_PROD*DATA_W   producer i data is bits [i*DATA_W +: DATA_W]
//  prod_ready  out  N_PROD          one-hot or zero; beat accepted from producer i
//  cons_valid  out  1               data presented to the consumer
//  cons_data   out  DATA_W          muxed data from the granted producer
//  cons_ready  in   1               consumer accepts the beat this cycle
//  grant_id    out  GID_W           current/last granted producer
//  busy        out  1               1 while in SERVE
//  xfer_count  out  16              total accepted beats; saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (reset==0) values:
//    state=IDLE, grant_id=N_PROD-1 (so producer 0 wins first), beat_cnt=0,
//    xfer_count=0; outputs prod_ready=0, cons_valid=0, cons_data=0, busy=0.
//  - Transfer condition: a beat transfers when cons_valid && cons_ready.
//    prod_ready[grant_id] = cons_ready in SERVE; all other prod_ready bits are 0.
//  - The cons_* outputs are combinational from the granted producer in SERVE.
//    They are forced to 0 in IDLE.
//  - FSM, two states:
//    IDLE: if |prod_valid, pick the first requester searching from grant_id+1,
//      wrapping modulo N_PROD. Register it into grant_id, set beat_cnt=0, go to SERVE.
//      Otherwise stay in IDLE.
//    SERVE, on each transfer: beat_cnt++ and xfer_count++ (saturating).
//      If beat_cnt+1 == BURST_MAX, go to IDLE.
//    SERVE, when prod_valid[grant_id]==0: go to IDLE (producer done).
//      No beat transfers that cycle.
//  - Latency: a request first seen at edge t is granted at t+1.
//    The first beat can transfer in the cycle following edge t+1.
//    Every return through IDLE costs exactly one bubble cycle.
//  - Producer protocol: once asserted, valid is held with stable data until accepted.
//    The arbiter never drops a grant while a beat is presented and ready is low.
//    It waits in SERVE indefinitely (no timeout).
//  - Fairness: a continuously requesting producer waits at most
//    (N_PROD-1)*(BURST_MAX+1) cycles of service by others.
//    This bound assumes cons_ready is held at 1.
//  - Boundaries:
//    - grant_id wrap N_PROD-1 -> 0.
//    - All producers requesting: strict rotation.
//    - Single requester: re-granted after a one-cycle bubble.
//    - BURST_MAX=1: rotates every beat.
//    - Transfer and valid drop in the same cycle: the transfer counts, then go IDLE.
//    - xfer_count holds at FFFF.
//    - Reset asserted mid-burst: outputs clear asynchronously and the beat is lost.
//      The consumer must ignore cons_valid during reset.
//  - No combinational path from cons_ready to cons_valid.
// STRUCTURE
//  - Shared package pc_pkg: state encoding ST_IDLE=1'b0, ST_SERVE=1'b1;
//    localparam CNT_W=4; XFER_W=16.
//  - Sub-module rr_pick (combinational), with ports:
//    req[N_PROD], last[GID_W] -> found, pick[GID_W].
//    Implementation: rotate req by last+1, priority-encode, rotate back.
//  - Top level: FSM register, beat counter, saturating xfer counter, output mux.
// TESTING
//  1. Reset: drive reset=0 mid-run.
//     -> all outputs 0 and grant_id=3 immediately, without waiting for a clock edge.
//     Release: first grant goes to producer 0.
//  2. Single producer: P2 streams 6 beats, cons_ready=1.
//     -> grant_id=2; beats 1-4 back-to-back, 1 bubble, beats 5-6; xfer_count=6.
//  3. All four producers: each holds valid with data=producer index, cons_ready=1.
//     -> grant order 0,1,2,3,0; 4 beats each; one bubble between grants.
//  4. Backpressure: P1 is granted and cons_ready=0 for 5 cycles.
//     -> cons_valid=1 and cons_data stable; prod_ready=0; grant held.
//     -> Transfer happens on the cycle cons_ready rises.
//  5. Early release: P3 sends 2 beats, then drops valid while P0 requests.
//     -> IDLE for 1 cycle, then grant_id=0 (wrap from 3).
//  6. Saturation: preload xfer_count to FFFE via force, send 3 beats.
//     -> xfer_count=FFFF, then holds.

Source files
------------

// File: rtl/pc_rr_arbiter_pkg.sv
// Shared definitions for the producer/consumer round-robin arbiter.
//   state_t : arbiter FSM state encoding (IDLE / SERVE)
//   CNT_W   : width of the per-grant beat counter
//   XFER_W  : width of the saturating accepted-beat counter
package pc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam int CNT_W  = 4;
    localparam int XFER_W = 16;

endpackage

// File: rtl/pc_rr_arbiter_rr_pick.sv
// Round-robin requester selection (purely combinational).
// Ports:
//   req   in  N_PROD  request vector, bit i = producer i wants service
//   last  in  GID_W   most recently granted producer
//   found out 1       at least one request is present
//   pick  out GID_W   first requester searching upward from last+1, wrapping
module rr_pick
    import pc_pkg::*;
#(
    parameter int N_PROD = 4,
    parameter int GID_W  = 2
) (
    input  logic [N_PROD-1:0] req,
    input  logic [GID_W-1:0]  last,
    output logic              found,
    output logic [GID_W-1:0]  pick
);

    logic [2*N_PROD-1:0] dbl;
    logic [N_PROD-1:0]   rot;
    int                  start;
    int                  k;
    int                  idx;

    always_comb begin
        // Rotate so that producer last+1 lands at bit 0.
        start = int'(last) + 1;
        if (start >= N_PROD) begin
            start = 0;
        end
        dbl = {req, req};
        rot = dbl[start +: N_PROD];

        // Lowest set bit of the rotated vector wins.
        k = 0;
        for (int i = N_PROD - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = i;
            end
        end
        found = |rot;

        // Rotate the winner's position back to a producer index.
        idx = start + k;
        if (idx >= N_PROD) begin
            idx = idx - N_PROD;
        end
        pick = GID_W'(idx);
    end

endmodule

// File: rtl/pc_rr_arbiter.sv
// Round-robin arbiter sharing one consumer between N_PROD producers with
// valid/ready handshakes and bursts of at most BURST_MAX beats per grant.
// Ports:
//   clock       in   1              rising-edge clock
//   reset       in   1              asynchronous active-low reset
//   prod_valid  in   N_PROD         producer i has a beat
//   prod_data   in   N_PROD*DATA_W  producer i data at [i*DATA_W +: DATA_W]
//   prod_ready  out  N_PROD         one-hot or zero; beat taken from producer i
//   cons_valid  out  1              beat presented to the consumer
//   cons_data   out  DATA_W         data of the granted producer
//   cons_ready  in   1              consumer takes the beat this cycle
//   grant_id    out  GID_W          current/last granted producer
//   busy        out  1              high while serving a grant
//   xfer_count  out  16             accepted beats, saturating at 16'hFFFF
module pc_rr_arbiter
    import pc_pkg::*;
#(
    parameter int N_PROD    = 4,
    parameter int DATA_W    = 4,
    parameter int BURST_MAX = 4,
    parameter int GID_W     = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_PROD-1:0]        prod_valid,
    input  logic [N_PROD*DATA_W-1:0] prod_data,
    output logic [N_PROD-1:0]        prod_ready,
    output logic                     cons_valid,
    output logic [DATA_W-1:0]        cons_data,
    input  logic                     cons_ready,
    output logic [GID_W-1:0]         grant_id,
    output logic                     busy,
    output logic [XFER_W-1:0]        xfer_count
);

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_MAX - 1);
    localparam logic [XFER_W-1:0] XFER_MAX  = '1;
    // Resetting to the highest index makes producer 0 the first winner.
    localparam logic [GID_W-1:0]  GID_RST   = GID_W'(N_PROD - 1);

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic             found;
    logic [GID_W-1:0] pick;

    rr_pick #(
        .N_PROD (N_PROD),
        .GID_W  (GID_W)
    ) u_pick (
        .req   (prod_valid),
        .last  (grant_id),
        .found (found),
        .pick  (pick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant_id   <= GID_RST;
            beat_cnt   <= '0;
            xfer_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_id <= pick;
                        beat_cnt <= '0;
                        state    <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (!prod_valid[grant_id]) begin
                        // Producer finished early; nothing transfers this cycle.
                        state <= ST_IDLE;
                    end else if (cons_ready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (xfer_count != XFER_MAX) begin
                            xfer_count <= xfer_count + 1'b1;
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Consumer side is a pure mux of the granted producer; cons_valid
    // depends only on registered state and prod_valid, never on cons_ready.
    always_comb begin
        prod_ready = '0;
        cons_valid = 1'b0;
        cons_data  = '0;
        if (state == ST_SERVE) begin
            cons_valid           = prod_valid[grant_id];
            cons_data            = prod_data[grant_id*DATA_W +: DATA_W];
            prod_ready[grant_id] = cons_ready;
        end
    end

    assign busy = (state == ST_SERVE);

endmodule

// File: tb/tb_pc_rr_arbiter.sv
module tb_pc_rr_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  prod_valid;
    logic [15:0] prod_data;
    logic [3:0]  prod_ready;
    logic        cons_valid;
    logic [3:0]  cons_data;
    logic        cons_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] xfer_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pc_rr_arbiter #(
        .N_PROD    (4),
        .DATA_W    (4),
        .BURST_MAX (4),
        .GID_W     (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .prod_ready (prod_ready),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .cons_ready (cons_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        prod_valid = 4'b0100;
        prod_data  = 16'h0300;
        cons_ready = 1'b0;
        next();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL reset_pre_grant: busy=%0b grant=%0d expected busy=1 grant=2", busy, grant_id);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (prod_ready !== 4'b0 || cons_valid !== 1'b0 || cons_data !== 4'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b cv=%b cd=%h busy=%b expected all 0",
                     prod_ready, cons_valid, cons_data, busy);
        end
        checks++;
        if (grant_id !== 2'd3 || xfer_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: grant=%0d xfer=%h expected grant=3 xfer=0000", grant_id, xfer_count);
        end
        @(negedge clock);
        reset      = 1'b1;
        prod_valid = 4'b1111;
        next();
        checks++;
        if (grant_id !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: grant=%0d busy=%b expected grant=0 busy=1", grant_id, busy);
        end
        prod_valid = 4'b0000;
        next();
        next();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_back_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single();
        logic [15:0] xb;
        logic [7:0]  pat;
        int          sent;
        logic        x;
        xb   = xfer_count;
        pat  = '0;
        sent = 0;
        prod_valid      = 4'b0100;
        prod_data[11:8] = 4'h8;
        cons_ready      = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (c >= 1) begin
                checks++;
                if (grant_id !== 2'd2) begin
                    errors++;
                    $display("FAIL single_grant: cycle %0d grant=%0d expected 2", c, grant_id);
                end
            end
            x = cons_valid && cons_ready;
            if (x) begin
                pat[c] = 1'b1;
                checks++;
                if (cons_data !== 4'(8 + sent)) begin
                    errors++;
                    $display("FAIL single_data: beat %0d data=%h expected %h", sent, cons_data, 4'(8 + sent));
                end
            end
            next();
            if (x) begin
                sent++;
                prod_data[11:8] = 4'(8 + sent);
                if (sent == 6) prod_valid = 4'b0000;
            end
        end
        checks++;
        if (pat !== 8'b1101_1110) begin
            errors++;
            $display("FAIL single_pattern: pattern=%b expected 11011110", pat);
        end
        checks++;
        if (xfer_count !== xb + 16'd6) begin
            errors++;
            $display("FAIL single_count: xfer=%h expected %h", xfer_count, xb + 16'd6);
        end
        next();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int j;
        int r;
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        prod_data  = 16'h3210;
        prod_valid = 4'b1111;
        cons_ready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clock);
            j = (c - 1) / 5;
            r = (c - 1) % 5;
            checks++;
            if (c == 0 || r == 4) begin
                if (busy !== 1'b0 || cons_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_bubble: cycle %0d busy=%b cv=%b expected 0 0", c, busy, cons_valid);
                end
            end else begin
                if (busy !== 1'b1 || cons_valid !== 1'b1 || grant_id !== 2'(j % 4) ||
                    cons_data !== 4'(j % 4) || prod_ready !== 4'(1 << (j % 4))) begin
                    errors++;
                    $display("FAIL rr_beat: cycle %0d grant=%0d data=%h ready=%b expected grant=%0d data=%0d",
                             c, grant_id, cons_data, prod_ready, j % 4, j % 4);
                end
            end
            next();
        end
        checks++;
        if (xfer_count !== 16'd20) begin
            errors++;
            $display("FAIL rr_count: xfer=%0d expected 20", xfer_count);
        end
        prod_valid = 4'b0000;
        next();
    endtask

    task automatic test_backpressure();
        logic [15:0] xb;
        xb = xfer_count;
        prod_valid = 4'b0010;
        prod_data  = 16'h0050;
        cons_ready = 1'b0;
        next();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            checks++;
            if (cons_valid !== 1'b1 || cons_data !== 4'h5 || prod_ready !== 4'b0 ||
                grant_id !== 2'd1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d cv=%b cd=%h ready=%b grant=%0d expected 1 5 0000 1",
                         c, cons_valid, cons_data, prod_ready, grant_id);
            end
            next();
        end
        checks++;
        if (xfer_count !== xb) begin
            errors++;
            $display("FAIL bp_no_count: xfer=%h expected %h", xfer_count, xb);
        end
        cons_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (prod_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_ready: ready=%b expected 0010", prod_ready);
        end
        next();
        checks++;
        if (xfer_count !== xb + 16'd1) begin
            errors++;
            $display("FAIL bp_count: xfer=%h expected %h", xfer_count, xb + 16'd1);
        end
        prod_valid = 4'b0000;
        cons_ready = 1'b0;
        next();
        next();
    endtask

    task automatic test_early_release();
        logic [15:0] xb;
        xb = xfer_count;
        prod_valid = 4'b1000;
        prod_data  = 16'h7000;
        cons_ready = 1'b1;
        next();
        @(negedge clock);
        checks++;
        if (grant_id !== 2'd3 || cons_valid !== 1'b1 || cons_data !== 4'h7) begin
            errors++;
            $display("FAIL er_grant3: grant=%0d cv=%b cd=%h expected 3 1 7", grant_id, cons_valid, cons_data);
        end
        next();
        next();
        prod_valid      = 4'b0001;
        prod_data[3:0]  = 4'h9;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || cons_valid !== 1'b0) begin
            errors++;
            $display("FAIL er_drop: busy=%b cv=%b expected 1 0", busy, cons_valid);
        end
        next();
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL er_bubble: busy=%b expected 0", busy);
        end
        next();
        @(negedge clock);
        checks++;
        if (grant_id !== 2'd0 || busy !== 1'b1 || cons_data !== 4'h9) begin
            errors++;
            $display("FAIL er_wrap: grant=%0d busy=%b cd=%h expected 0 1 9", grant_id, busy, cons_data);
        end
        next();
        prod_valid = 4'b0000;
        checks++;
        if (xfer_count !== xb + 16'd3) begin
            errors++;
            $display("FAIL er_count: xfer=%h expected %h", xfer_count, xb + 16'd3);
        end
        next();
        next();
    endtask

    task automatic test_saturation();
        force dut.xfer_count = 16'hFFFE;
        next();
        release dut.xfer_count;
        checks++;
        if (xfer_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_preload: xfer=%h expected fffe", xfer_count);
        end
        prod_valid     = 4'b0001;
        prod_data[3:0] = 4'h1;
        cons_ready     = 1'b1;
        next();
        for (int b = 0; b < 3; b++) begin
            @(negedge clock);
            checks++;
            if (cons_valid !== 1'b1) begin
                errors++;
                $display("FAIL sat_valid: beat %0d cv=%b expected 1", b, cons_valid);
            end
            next();
            checks++;
            if (xfer_count !== 16'hFFFF) begin
                errors++;
                $display("FAIL sat_count: beat %0d xfer=%h expected ffff", b, xfer_count);
            end
        end
        prod_valid = 4'b0000;
        next();
        next();
        checks++;
        if (xfer_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: xfer=%h expected ffff", xfer_count);
        end
    endtask

    initial begin
        reset      = 1'b0;
        prod_valid = 4'b0000;
        prod_data  = 16'h0000;
        cons_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_early_release();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
